shift_mix_round: RTL
====================

SHIFT_MIX_ROUND -- requirements
Module: shift_mix_round

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 in_valid  input  1  upstream offers a state word this cycle.
REQ-004 in_ready  output  1  block accepts; transfer when in_valid && in_ready.
REQ-005 s_state  input  128  state in, bit order [0:127]; byte k = bits [8k:8k+7], k = 4*col + row.
REQ-006 round_key  input  128  round key, same byte order, sampled with s_state on accept.
REQ-007 final_round  input  1  1 = skip MixColumns for this word; sampled on accept.
REQ-008 out_valid  output  1  result on round_state is valid.
REQ-009 out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-010 round_state  output  128  ShiftRows -> (MixColumns) -> AddRoundKey result, same byte order.
REQ-011 occupancy  output  2  words held in the pipeline, 0..2.

Function
REQ-012 Forward ShiftRows SHALL map out byte k from in byte: 0<-0, 1<-5, 2<-10, 3<-15, 4<-4, 5<-9, 6<-14, 7<-3, 8<-8, 9<-13, 10<-2, 11<-7, 12<-12, 13<-1, 14<-6, 15<-11. This is the exact inverse of the decryption-side inverse shift.
REQ-013 MixColumns SHALL operate per column (bytes 4c..4c+3) with matrix [02 03 01 01; 01 02 03 01; 01 01 02 03; 03 01 01 02] over GF(2^8), modulus 0x11B.
REQ-014 xtime SHALL be (b<<1) XOR (b[msb] ? 0x1B : 0x00), truncated to 8 bits.
REQ-015 Stage 1 register SHALL capture ShiftRows(s_state), with MixColumns applied when final_round=0. Stage 1 SHALL also capture round_key and a valid bit.
REQ-016 Stage 2 register SHALL capture stage1_data XOR stage1_key and drive round_state; out_valid SHALL be the stage-2 valid bit.
REQ-017 Latency SHALL be exactly 2 cycles from input accept to out_valid when unstalled. Throughput SHALL be 1 word per cycle.
REQ-018 Stage 2 SHALL load when !out_valid || out_ready.
REQ-019 Stage 1 SHALL load when !s1_valid || stage 2 loads.
REQ-020 in_ready SHALL equal the stage-1 load condition, combinational from out_ready and the valid bits.
REQ-021 When out_valid=1 and out_ready=0, round_state and out_valid SHALL hold stable; no data is lost or duplicated.
REQ-022 A stage whose upstream is empty while it loads SHALL clear its valid bit (bubble).
REQ-023 Simultaneous accept and output transfer with both stages full SHALL shift both stages in the same cycle; occupancy is unchanged.
REQ-024 occupancy SHALL be s1_valid + out_valid.
REQ-025 in_valid while in_ready=0 SHALL be ignored; upstream holds its word.
REQ-026 Data registers SHALL change only on their load enable.

Reset
REQ-027 On rst_n=0, valid bits, occupancy and round_state SHALL clear to 0 immediately, without waiting for clk.
REQ-028 After reset, in_ready SHALL be 1.
REQ-029 Reset mid-operation SHALL discard all in-flight words; no stale out_valid pulse after release.
REQ-030 Stage-1 data/key registers SHALL reset to 0.

Verification
REQ-031 FIPS-197 App. B round 1:
- stimulus: s_state d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 (post-SubBytes), key a0 fa fe 17 88 54 2c b1 23 a3 39 39 2a 6c 76 05, final_round=0, out_ready=1
- response: round_state a4 9c 7f f2 68 9f 35 2b 6b 5b ea 43 02 6a 50 49, exactly 2 cycles after accept.
REQ-032 ShiftRows-only check:
- stimulus: s_state 00 01 02 .. 0f, key 0, final_round=1
- response: 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b.
REQ-033 MixColumns check:
- stimulus: column 0 pre-shift placed so that post-shift column 0 = db 13 53 45, key 0, final_round=0
- response: output column 0 = 8e 4d a1 bc.
REQ-034 Backpressure:
- stimulus: 3 back-to-back words, out_ready=0 for 4 cycles
- response: occupancy reaches 2, in_ready=0, round_state stable; after out_ready=1 the words emerge in order, none dropped or duplicated.
REQ-035 Streaming and reset:
- stimulus: 8 consecutive words with out_ready=1, then rst_n=0 asserted mid-clock with occupancy=2
- response: 8 outputs on consecutive cycles; at reset, out_valid=0 and occupancy=0 immediately, in_ready=1 after release.

Source files
------------

// File: rtl/shift_mix_round.sv
// One encryption round after SubBytes: ShiftRows, optional MixColumns, AddRoundKey.
// Two-stage valid/ready pipeline with full throughput and stall propagation.
`timescale 1ns/1ps

module shift_mix_round (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] s_state,
    input  logic [0:127] round_key,
    input  logic         final_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] round_state,
    output logic [1:0]   occupancy
);

    // Source byte index for each output byte of the forward row rotation.
    localparam int SHIFT_SRC [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:127] shift_rows(input logic [0:127] s);
        logic [0:127] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            r[8*k +: 8] = s[8*SHIFT_SRC[k] +: 8];
        end
        return r;
    endfunction

    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            r[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    logic         s1_valid;
    logic [0:127] s1_data;
    logic [0:127] s1_key;
    logic [0:127] s1_next;
    logic         s2_load;
    logic         s1_load;

    // A stage may advance when its successor is empty or is itself draining.
    assign s2_load   = !out_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = s1_load;
    assign occupancy = 2'(s1_valid) + 2'(out_valid);

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        s1_next = shift_rows(s_state);
        if (!final_round) begin
            s1_next = mix_columns(s1_next);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so both stages shift from pre-edge values.
    // NOTE: the data/key registers are reset too, so the pipeline contents are known right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_data     <= '0;
            s1_key      <= '0;
            out_valid   <= 1'b0;
            round_state <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_data <= s1_next;
                    s1_key  <= round_key;
                end
            end
            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    round_state <= s1_data ^ s1_key;
                end
            end
        end
    end

endmodule
